shared_reg_arb: RTL and testbench
=================================

Name: shared_reg_arb

Overview:
- Round-robin write arbiter for one shared WIDTH-bit register.
- NREQ requesters compete to load their data into a single enabled register.
- The arbiter selects one winner per cycle and drives the register enable and data.
- It returns a one-cycle grant to the winner and exports the register contents and the identity of the last writer.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 4, width of the shared register and of each requester's data.
- IDW, $clog2(NREQ), derived width of the requester index; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  NREQ  per-requester write request; req[i] belongs to requester i.
- wdata  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot write acknowledge.
- q  output  WIDTH  current shared register contents.
- owner  output  IDW  index of the requester that last wrote q.
- q_valid  output  1  high once q has been written at least once since reset.

Behaviour:
- Reset (rst_n low at a rising clk): all of the following are cleared on that edge.
  - q=0, gnt=0, owner=0, q_valid=0.
  - Priority pointer ptr=0, so requester 0 has top priority.
  - Reset dominates every other event, including a grant in flight.
- Eligibility, evaluated combinationally each cycle:
  - Requester i is eligible when req[i]=1 and gnt[i]=0.
  - A requester being acknowledged this cycle is masked, so a req still held during its gnt cycle does not cause a double write.
- Selection:
  - Among eligible requesters, the winner is the first index found by scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
- Write, on the rising edge after selection, when a winner w exists:
  - q <= wdata[w].
  - owner <= w.
  - q_valid <= 1.
  - gnt <= one-hot(w).
  - ptr <= (w+1) mod NREQ, wrapping from NREQ-1 to 0.
- No eligible requester:
  - gnt <= 0.
  - q, owner, q_valid and ptr hold.
- Latency:
  - req[i] is sampled at edge t.
  - q is updated and gnt[i] is high during cycle t..t+1.
  - gnt is exactly one cycle wide per write.
- Handshake:
  - A requester holds req and wdata stable until it sees its gnt bit.
  - It may deassert req in the gnt cycle or keep it high to request another write.
  - A request still held after the masked cycle is eligible again on the next cycle.
- Withdrawal: req may drop before a grant without any effect. No grant is issued and state is unchanged.
- Fairness:
  - With every req held continuously, the grant sequence is 0,1,...,NREQ-1,0,...
  - One write happens per cycle.
  - No requester waits more than NREQ-1 writes.
- Data width: wdata slices are passed to q unmodified, with no arithmetic.
- gnt is at most one-hot in every cycle, and gnt=0 throughout reset.

Decomposition:
- Shared package: the requester-index width helper (clog2-based IDW) and the default NREQ/WIDTH constants, so sibling blocks agree on the owner encoding.
- Sub-module rr_pick: purely combinational.
  - Inputs: eligible vector and ptr.
  - Outputs: found flag and winner index.
  - Rotate-mask-priority encode.
- q storage reuses the team's existing enabled flop (dff_en).
  - en = found; D = selected wdata slice.
  - Its reset also uses rst_n.
- gnt, owner, q_valid and ptr are local registers.

Test Plan (NREQ=4, WIDTH=4):
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> q=0, gnt=0, owner=0, q_valid=0 throughout; first grant after release goes to requester 0.
- Single write: req=4'b0100, wdata[2]=4'hA for one edge -> next cycle q=4'hA, owner=2, gnt=4'b0100 for exactly one cycle, q_valid=1; then gnt=0 and q holds 4'hA.
- Saturation: req=4'b1111 held, wdata[i]=i+1 -> gnt cycles 0001,0010,0100,1000,0001; q follows 1,2,3,4,1; never two consecutive grants to the same index.
- Rotation/wrap: after requester 2 wins, assert req=4'b1001 -> requester 3 wins first (q=wdata[3]), then requester 0; ptr wraps 3->0.
- Mid-operation reset: rst_n=0 in the cycle gnt=4'b0010 with req=4'b1111 -> next edge gnt=0, q=0, q_valid=0; after release, requester 0 wins first.
- Withdrawal: req[1] pulsed for zero edges while requester 3 holds req -> only gnt=4'b1000 appears; q=wdata[3], owner=3.

Source files
------------

// File: rtl/shared_reg_arb_pkg.sv
// Shared constants and the requester-index width helper, so every block
// agrees on how a requester identity (owner, ptr, winner) is encoded.
package shared_reg_arb_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shared_reg_arb_if.sv
// Requester-side bus of the shared register arbiter: requests, write data,
// per-requester acknowledge and the exported register view.
interface shared_reg_arb_if
   import shared_reg_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
);

   localparam int IDW = idx_w(NREQ);

   // Handshake: req[i] acts as valid and gnt[i] as a one-cycle acknowledge.
   // Requester i keeps req[i] and its wdata slice stable until it sees gnt[i];
   // in the gnt cycle it may drop req[i] or keep it high for another write,
   // which becomes eligible one cycle after the acknowledge.
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic [IDW-1:0]        owner;
   logic                  q_valid;

   modport master (
      output req,
      output wdata,
      input  gnt,
      input  q,
      input  owner,
      input  q_valid
   );

   modport slave (
      input  req,
      input  wdata,
      output gnt,
      output q,
      output owner,
      output q_valid
   );

endinterface

// File: rtl/dff_en.sv
// Enabled register with synchronous active-low clear.
module dff_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shared_reg_arb_rr_pick.sv
// Round-robin pick: first eligible index scanning from ptr upward with wrap.
module rr_pick
   import shared_reg_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = idx_w(DEF_NREQ)
) (
   input  logic [NREQ-1:0] elig,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  win
);

   always_comb begin
      int             idx;
      logic [IDW-1:0] idx_v;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      idx_v = '0;
      // Offset k walks the rotated vector; the first hit is the winner.
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_v = IDW'(idx);
         if (!found && elig[idx_v]) begin
            found = 1'b1;
            win   = idx_v;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin write arbiter in front of one shared register: one winner per
// cycle loads its data, receives a one-cycle gnt and becomes the owner.
module shared_reg_arb
   import shared_reg_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   shared_reg_arb_if.slave bus
);

   localparam int IDW = idx_w(NREQ);

   logic [NREQ-1:0]  gnt_d,     gnt_q;
   logic [IDW-1:0]   owner_d,   owner_q;
   logic             q_valid_d, q_valid_q;
   logic [IDW-1:0]   ptr_d,     ptr_q;

   logic [NREQ-1:0]  elig;
   logic             found;
   logic [IDW-1:0]   win;
   logic [WIDTH-1:0] wsel;
   logic [WIDTH-1:0] q_w;

   // Masking the requester acknowledged this cycle prevents a double write
   // when it still holds req during its gnt cycle.
   assign elig = bus.req & ~gnt_q;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .elig  (elig),
      .ptr   (ptr_q),
      .found (found),
      .win   (win)
   );

   assign wsel = bus.wdata[int'(win)*WIDTH +: WIDTH];

   dff_en #(
      .W (WIDTH)
   ) u_q (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (found),
      .d     (wsel),
      .q     (q_w)
   );

   always_comb begin
      gnt_d     = '0;
      owner_d   = owner_q;
      q_valid_d = q_valid_q;
      ptr_d     = ptr_q;
      if (found) begin
         gnt_d     = NREQ'(1) << win;
         owner_d   = win;
         q_valid_d = 1'b1;
         ptr_d     = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_q     <= '0;
         owner_q   <= '0;
         q_valid_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         q_valid_q <= q_valid_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.q       = q_w;
   assign bus.owner   = owner_q;
   assign bus.q_valid = q_valid_q;

   a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_q));
   a_rst_clear  : assert property (@(posedge clk) !rst_n |=> (gnt_q == '0));

endmodule

// File: tb/tb_shared_reg_arb.sv
// Bench for shared_reg_arb (NREQ=4, WIDTH=4): directed vector table,
// hand-written withdrawal sequences, then randomized traffic vs a model.
module tb_shared_reg_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic clk;
   logic rst_n;

   shared_reg_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   shared_reg_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [15:0] wdata;
      logic [3:0]  gnt;
      logic [3:0]  q;
      logic [1:0]  owner;
      logic        qv;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] qe,
                          input logic [1:0] o, input logic v);
      chk({tag, ".gnt"},     32'(bus.gnt),     32'(g));
      chk({tag, ".q"},       32'(bus.q),       32'(qe));
      chk({tag, ".owner"},   32'(bus.owner),   32'(o));
      chk({tag, ".q_valid"}, 32'(bus.q_valid), 32'(v));
   endtask

   // Reference model state, kept as plain integers.
   int         m_ptr;
   int         m_gnt;
   int         m_owner;
   logic [3:0] m_q;
   logic       m_v;
   logic [3:0] d_v [NREQ];
   logic       rq  [NREQ];
   int         wait_c [NREQ];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // reset held, saturation, mid-op reset, single write, wrap, held req
      vecs.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'h0, 2'd0, 1'b0});
      vecs.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'h0, 2'd0, 1'b0});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0001, 4'h1, 2'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0010, 4'h2, 2'd1, 1'b1});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0100, 4'h3, 2'd2, 1'b1});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b1000, 4'h4, 2'd3, 1'b1});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0001, 4'h1, 2'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0010, 4'h2, 2'd1, 1'b1});
      vecs.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'h0, 2'd0, 1'b0});
      vecs.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0001, 4'h1, 2'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b0000, 16'h4321, 4'b0000, 4'h1, 2'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b0100, 16'h4A21, 4'b0100, 4'hA, 2'd2, 1'b1});
      vecs.push_back('{1'b1, 4'b0000, 16'h4A21, 4'b0000, 4'hA, 2'd2, 1'b1});
      vecs.push_back('{1'b1, 4'b1001, 16'h5A26, 4'b1000, 4'h5, 2'd3, 1'b1});
      vecs.push_back('{1'b1, 4'b1001, 16'h5A26, 4'b0001, 4'h6, 2'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b0000, 16'h5A26, 4'b0000, 4'h6, 2'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b0100, 16'h7B26, 4'b0100, 4'hB, 2'd2, 1'b1});
      vecs.push_back('{1'b1, 4'b0100, 16'h7B26, 4'b0000, 4'hB, 2'd2, 1'b1});
      vecs.push_back('{1'b1, 4'b0100, 16'h7B26, 4'b0100, 4'hB, 2'd2, 1'b1});
      vecs.push_back('{1'b1, 4'b0000, 16'h7B26, 4'b0000, 4'hB, 2'd2, 1'b1});

      rst_n     = 1'b0;
      bus.req   = '0;
      bus.wdata = '0;

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n     = vecs[i].rst_n;
         bus.req   = vecs[i].req;
         bus.wdata = vecs[i].wdata;
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].owner, vecs[i].qv);
      end

      // Withdrawal: req[1] pulses between edges while requester 3 holds req.
      bus.req = 4'b1000;
      #1 bus.req = 4'b1010;
      #2 bus.req = 4'b1000;
      tick();
      chk_out("withdraw_a", 4'b1000, 4'h7, 2'd3, 1'b1);
      // Now ptr=0, so req[1] would win if the pulse were ever sampled.
      bus.req = 4'b0000;
      #1 bus.req = 4'b0010;
      #2 bus.req = 4'b0000;
      tick();
      chk_out("withdraw_b", 4'b0000, 4'h7, 2'd3, 1'b1);

      // Randomized traffic following the requester handshake.
      m_ptr = 0; m_gnt = -1; m_owner = 0; m_q = '0; m_v = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         rq[i] = 1'b0; d_v[i] = '0; wait_c[i] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic       r;
         int         win;
         logic [3:0] exp_gnt;
         r = (cyc == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (m_gnt == i) begin
               if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
               else d_v[i] = 4'($urandom_range(0, 15));
            end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
               rq[i]  = 1'b1;
               d_v[i] = 4'($urandom_range(0, 15));
            end
         end
         rst_n = r;
         for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                   = rq[i];
            bus.wdata[i*WIDTH +: WIDTH]  = d_v[i];
         end

         if (!r) begin
            m_ptr = 0; m_gnt = -1; m_owner = 0; m_q = '0; m_v = 1'b0;
         end else begin
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (win < 0 && rq[idx] && idx != m_gnt) win = idx;
            end
            if (win >= 0) begin
               m_q     = d_v[win];
               m_owner = win;
               m_v     = 1'b1;
               m_ptr   = (win + 1) % NREQ;
            end
            m_gnt = win;
         end
         exp_gnt = (m_gnt < 0) ? 4'b0000 : 4'(1 << m_gnt);

         tick();
         chk_out($sformatf("rnd%0d", cyc), exp_gnt, m_q, 2'(m_owner), m_v);

         // Waiting bound measured from the observed grants.
         for (int i = 0; i < NREQ; i++) begin
            if (!r) begin
               wait_c[i] = 0;
            end else if (bus.gnt[i]) begin
               chk($sformatf("fair_wait%0d", i), 32'(wait_c[i] > NREQ - 1), 32'(0));
               wait_c[i] = 0;
            end else if (rq[i] && bus.gnt != '0) begin
               wait_c[i]++;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
